scc_wave_ram_arbiter: RTL
=========================

Name: scc_wave_ram_arbiter

Overview:
Schedules CPU wave-RAM accesses into the SCC channel mixer's shared wave RAM port. Accepts one CPU request at a time over a valid/ready handshake and decodes the SCC or SCC-I wave address map into the mixer's RAM id and address. Drives single-cycle RAM strobes only at a chosen scan phase, with a starvation timeout, so tone-scan stalls stay bounded. Returns read data through a response pulse. Sits between the cartridge bus decoder and the mixer.

Parameters:
SLOT_PHASE, 3'd0, mixer scan phase (value of active) at which an access is issued
MAX_WAIT, 8, cycles in WAIT_SLOT after which the access is forced regardless of phase (1..255)
OPEN_BUS, 8'hFF, read data returned for unmapped addresses

Ports:
nreset  input  1  asynchronous reset, active low
clk  input  1  system clock
reg_scci_enable  input  1  0: SCC map, 1: SCC-I map
req_valid  input  1  CPU request present
req_ready  output  1  arbiter can accept a request
req_write  input  1  1 write, 0 read
req_address  input  8  wave-window offset (0x00-0xFF)
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle read-data pulse
rsp_rdata  output  8  read data, valid with rsp_valid
active  input  3  mixer scan phase
sram_id  output  3  mixer RAM bank select (A..E)
sram_a  output  5  mixer RAM address
sram_d  output  8  mixer write data
sram_oe  output  1  mixer read strobe
sram_we  output  1  mixer write strobe
sram_q  input  8  mixer read data
sram_q_en  input  1  mixer read-data qualifier
busy  output  1  state is not IDLE

Behaviour:
- Reset: nreset is asynchronous and active low. All outputs are 0 except req_ready, which is 1. FSM goes to IDLE. wait_cnt = 0. Any in-flight request is dropped without a response.
- Decode is latched at acceptance (req_valid & req_ready). A later change of reg_scci_enable does not affect a pending request.
  - SCC map (reg_scci_enable = 0): 0x00-0x7F maps to id = {1'b0, addr[6:5]}, a = addr[4:0]. 0x80-0xFF is unmapped.
  - SCC-I map (reg_scci_enable = 1): 0x00-0x9F maps to id = addr[7:5], a = addr[4:0]. 0xA0-0xFF is unmapped.
- FSM states: IDLE, WAIT_SLOT, ISSUE, CAPTURE, RESP.
  - IDLE: req_ready = 1. On accept:
    - mapped request: go to WAIT_SLOT.
    - unmapped read: go to RESP with data = OPEN_BUS.
    - unmapped write: discarded; stay in IDLE.
  - WAIT_SLOT: req_ready = 0; wait_cnt increments each cycle.
    - If active == SLOT_PHASE, or wait_cnt == MAX_WAIT-1, go to ISSUE.
  - ISSUE: registered sram_oe or sram_we is high for exactly this one cycle. sram_id, sram_a and sram_d are stable during it.
    - Write: return to IDLE; no response is produced.
    - Read: go to CAPTURE.
  - CAPTURE: sram_q is latched on the cycle sram_q_en = 1, then go to RESP.
    - If sram_q_en is not seen within 2 cycles, latch OPEN_BUS and go to RESP (protocol-error fallback).
  - RESP: rsp_valid = 1 for one cycle with rsp_rdata, then return to IDLE.
- Latency:
  - Read with immediate slot: accept at edge E0, strobe during E1-E2, rsp_valid during E3-E4.
  - Write: strobe 1 cycle after the slot, or forced issue, is reached.
- sram_oe and sram_we are never high together, and never high for 2 consecutive cycles.
- Strobes are low in all states other than ISSUE. sram_d = 0 on reads.
- rsp_rdata holds its last value between pulses.
- wait_cnt clears on entry to WAIT_SLOT.
- Back-to-back requests: req_ready returns the cycle after RESP, or after ISSUE for writes. There is no bypass.

Optional Feature:
SCC_ARB_POST_WRITE_EN
- Defined:
  - A 2-entry write FIFO posts writes. req_ready stays high for writes while the FIFO is not full, including during WAIT_SLOT, ISSUE and CAPTURE of another access.
  - A read is accepted only when the FIFO is empty and the FSM is IDLE.
  - FIFO entries drain in order through WAIT_SLOT/ISSUE.
  - busy = FSM not IDLE or FIFO not empty.
- Undefined: single-entry behaviour exactly as above.

Decomposition:
- Package scc_arb_pkg holds the state encoding, the map limits (SCC_LIMIT = 8'h80, SCCI_LIMIT = 8'hA0) and the id encodings A..E.
- One sub-module, scc_arb_write_fifo (2-deep, full/empty flags), instantiated only under SCC_ARB_POST_WRITE_EN.

Test Plan:
- SCC mode, read 0x45 with active == SLOT_PHASE on the cycle after accept, mixer returns 0x5A -> sram_id = 2, sram_a = 5, sram_oe high for 1 cycle; rsp_valid with rsp_rdata = 0x5A, 4 cycles after accept.
- SCC-I mode, write 0x9F = 0x33 -> sram_id = 4, sram_a = 31, sram_we high for 1 cycle with sram_d = 0x33; rsp_valid stays 0.
- SCC mode, read 0x90 -> no strobe; rsp_valid with rsp_rdata = 0xFF, 2 cycles after accept.
- active held away from SLOT_PHASE, MAX_WAIT = 8 -> forced strobe after 8 WAIT_SLOT cycles.
- nreset pulsed during WAIT_SLOT -> strobes 0, req_ready = 1, no rsp_valid afterwards.
- reg_scci_enable toggled 0->1 after accept of 0x85 (unmapped in SCC) -> still answered 0xFF, with no strobe.

Source files
------------

// File: rtl/scc_arb_pkg.sv
// Shared definitions for the SCC wave-RAM arbiter: FSM state encoding,
// wave-window map limits, mixer RAM bank ids and the address decoder.
package scc_arb_pkg;

    // Arbiter FSM states
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitSlot = 3'd1;
    localparam logic [2:0] StIssue    = 3'd2;
    localparam logic [2:0] StCapture  = 3'd3;
    localparam logic [2:0] StResp     = 3'd4;

    // First unmapped offset of each wave window
    localparam logic [7:0] SCC_LIMIT  = 8'h80;
    localparam logic [7:0] SCCI_LIMIT = 8'hA0;

    // Mixer RAM bank ids
    localparam logic [2:0] ID_A = 3'd0;
    localparam logic [2:0] ID_B = 3'd1;
    localparam logic [2:0] ID_C = 3'd2;
    localparam logic [2:0] ID_D = 3'd3;
    localparam logic [2:0] ID_E = 3'd4;

    typedef struct packed {
        logic       mapped;
        logic [2:0] id;
        logic [4:0] a;
    } wave_dec_t;

    // Posted write as held in the write FIFO
    typedef struct packed {
        logic [2:0] id;
        logic [4:0] a;
        logic [7:0] d;
    } wr_entry_t;

    // SCC exposes banks A..D over 0x00-0x7F; SCC-I adds bank E up to 0x9F.
    function automatic wave_dec_t wave_decode(input logic [7:0] addr, input logic scci);
        wave_dec_t dec;
        dec.a = addr[4:0];
        if (scci) begin
            dec.mapped = (addr < SCCI_LIMIT);
            dec.id     = addr[7:5];
        end else begin
            dec.mapped = (addr < SCC_LIMIT);
            dec.id     = {1'b0, addr[6:5]};
        end
        return dec;
    endfunction

endpackage

// File: rtl/scc_arb_write_fifo.sv
// Two-entry posted-write FIFO for the wave-RAM arbiter. Only instantiated
// when SCC_ARB_POST_WRITE_EN is defined.
module scc_arb_write_fifo
    import scc_arb_pkg::*;
(
    input  logic      clk,
    input  logic      nreset,
    input  logic      push,
    input  wr_entry_t wdata,
    input  logic      pop,
    output wr_entry_t rdata,
    output logic      full,
    output logic      empty
);

    wr_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/scc_wave_ram_arbiter.sv
// Schedules CPU wave-RAM accesses onto the SCC mixer's shared RAM port.
// Strobes are issued only at the mixer scan phase SLOT_PHASE, or after
// MAX_WAIT cycles of waiting, so tone-scan stalls stay bounded.
// Optional: define SCC_ARB_POST_WRITE_EN for a 2-entry posted-write FIFO.
module scc_wave_ram_arbiter
    import scc_arb_pkg::*;
#(
    parameter logic [2:0]  SLOT_PHASE = 3'd0,
    parameter int unsigned MAX_WAIT   = 8,
    parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
    input  logic       nreset,
    input  logic       clk,
    input  logic       reg_scci_enable,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_address,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic [2:0] active,
    output logic [2:0] sram_id,
    output logic [4:0] sram_a,
    output logic [7:0] sram_d,
    output logic       sram_oe,
    output logic       sram_we,
    input  logic [7:0] sram_q,
    input  logic       sram_q_en,
    output logic       busy
);

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       cap_cnt_q, cap_cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       write_q;
    logic [2:0] id_q;
    logic [4:0] a_q;
    logic [7:0] d_q;
    logic       oe_q, we_q;
    logic       load;

    wave_dec_t  dec;
    logic       accept;
    logic       open_read;
    // Access handed to the FSM when it leaves IDLE towards WAIT_SLOT
    logic       start_valid;
    logic       start_write;
    logic [2:0] start_id;
    logic [4:0] start_a;
    logic [7:0] start_d;

    assign dec       = wave_decode(req_address, reg_scci_enable);
    assign accept    = req_valid && req_ready;
    assign open_read = accept && !req_write && !dec.mapped;

`ifdef SCC_ARB_POST_WRITE_EN
    wr_entry_t fifo_wdata;
    wr_entry_t fifo_rdata;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;

    // Writes post while there is room; reads need a fully quiet arbiter.
    assign req_ready   = req_write ? !fifo_full : ((state_q == StIdle) && fifo_empty);
    assign fifo_push   = accept && req_write && dec.mapped;
    assign fifo_wdata  = '{id: dec.id, a: dec.a, d: req_wdata};
    assign fifo_pop    = (state_q == StIdle) && !fifo_empty;
    assign start_valid = fifo_pop || (accept && !req_write && dec.mapped);
    assign start_write = fifo_pop;
    assign start_id    = fifo_pop ? fifo_rdata.id : dec.id;
    assign start_a     = fifo_pop ? fifo_rdata.a : dec.a;
    assign start_d     = fifo_pop ? fifo_rdata.d : 8'h00;
    assign busy        = (state_q != StIdle) || !fifo_empty;

    scc_arb_write_fifo u_write_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
`else
    assign req_ready   = (state_q == StIdle);
    assign start_valid = accept && dec.mapped;
    assign start_write = req_write;
    assign start_id    = dec.id;
    assign start_a     = dec.a;
    assign start_d     = req_write ? req_wdata : 8'h00;
    assign busy        = (state_q != StIdle);
`endif

    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign sram_id   = id_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;
    assign sram_oe   = oe_q;
    assign sram_we   = we_q;

    // Next-state, wait/capture counters and read-data selection
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        rdata_d    = rdata_q;
        load       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_valid) begin
                    load       = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = StWaitSlot;
                end else if (open_read) begin
                    rdata_d = OPEN_BUS;
                    state_d = StResp;
                end
            end
            StWaitSlot: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if ((active == SLOT_PHASE) || (wait_cnt_q == LastWait)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cap_cnt_d = 1'b0;
                state_d   = write_q ? StIdle : StCapture;
            end
            StCapture: begin
                if (sram_q_en) begin
                    rdata_d = sram_q;
                    state_d = StResp;
                end else if (cap_cnt_q) begin
                    // Mixer never qualified the data: answer open bus
                    rdata_d = OPEN_BUS;
                    state_d = StResp;
                end else begin
                    cap_cnt_d = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched access and strobes registered off the next state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            cap_cnt_q  <= 1'b0;
            rdata_q    <= 8'h00;
            write_q    <= 1'b0;
            id_q       <= 3'd0;
            a_q        <= 5'd0;
            d_q        <= 8'h00;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            rdata_q    <= rdata_d;
            oe_q       <= (state_d == StIssue) && !write_q;
            we_q       <= (state_d == StIssue) && write_q;
            if (load) begin
                write_q <= start_write;
                id_q    <= start_id;
                a_q     <= start_a;
                d_q     <= start_d;
            end
        end
    end

endmodule
